// File: rtl/mem_test_sequencer.sv
// Write-then-verify sequencer for a simple dual-port block RAM: fills every word with a
// seeded, address-derived pattern, then reads the memory back and counts mismatches.
module mem_test_sequencer #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 16384
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [DATA_W-1:0]   seed_i,
    output logic [ADDR_W-1:0]   waddr_o,
    output logic [DATA_W-1:0]   din_o,
    output logic [ADDR_W-1:0]   raddr_o,
    input  logic [DATA_W-1:0]   mem_dout_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                pass_o,
    output logic [ADDR_W:0]     err_count_o,
    output logic [ADDR_W-1:0]   first_err_addr_o
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } state_e;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    // Only the low two nibbles of the address feed the pattern; upper bits act as zeros.
    function automatic logic [DATA_W-1:0] pattern(input logic [2*DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0]   s);
        return a[DATA_W-1:0] ^ a[2*DATA_W-1:DATA_W] ^ s;
    endfunction

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   seed_q, seed_d;
    logic [ADDR_W-1:0]   holdAddr_q, holdAddr_d;
    logic [DATA_W-1:0]   holdDin_q, holdDin_d;
    logic [ADDR_W-1:0]   raddrHold_q, raddrHold_d;
    logic                rdValid_q, rdValid_d;
    logic [ADDR_W-1:0]   rdAddr_q, rdAddr_d;
    logic [ADDR_W:0]     errCount_q, errCount_d;
    logic [ADDR_W-1:0]   firstErr_q, firstErr_d;
    logic                errSeen_q, errSeen_d;
    logic                mismatch;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            seed_q      <= '0;
            holdAddr_q  <= '0;
            holdDin_q   <= '0;
            raddrHold_q <= '0;
            rdValid_q   <= 1'b0;
            rdAddr_q    <= '0;
            errCount_q  <= '0;
            firstErr_q  <= '0;
            errSeen_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            seed_q      <= seed_d;
            holdAddr_q  <= holdAddr_d;
            holdDin_q   <= holdDin_d;
            raddrHold_q <= raddrHold_d;
            rdValid_q   <= rdValid_d;
            rdAddr_q    <= rdAddr_d;
            errCount_q  <= errCount_d;
            firstErr_q  <= firstErr_d;
            errSeen_q   <= errSeen_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        seed_d      = seed_q;
        holdAddr_d  = holdAddr_q;
        holdDin_d   = holdDin_q;
        raddrHold_d = raddrHold_q;
        rdValid_d   = 1'b0;
        rdAddr_d    = cnt_q;
        errCount_d  = errCount_q;
        firstErr_d  = firstErr_q;
        errSeen_d   = errSeen_q;

        // Read data arrives one cycle after its address; compare against the delayed address.
        mismatch = rdValid_q && (mem_dout_i != pattern(rdAddr_q[2*DATA_W-1:0], seed_q));
        if (mismatch) begin
            errCount_d = errCount_q + (ADDR_W+1)'(1);
            if (!errSeen_q) begin
                firstErr_d = rdAddr_q;
                errSeen_d  = 1'b1;
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    seed_d     = seed_i;
                    errCount_d = '0;
                    firstErr_d = '0;
                    errSeen_d  = 1'b0;
                    cnt_d      = '0;
                    state_d    = WRITE;
                end
            end
            WRITE: begin
                if (cnt_q == LAST) begin
                    // Park the write port on the last word so the unconditional write is harmless.
                    cnt_d      = '0;
                    holdAddr_d = LAST;
                    holdDin_d  = pattern(LAST[2*DATA_W-1:0], seed_q);
                    state_d    = READ;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            READ: begin
                rdValid_d   = 1'b1;
                raddrHold_d = cnt_q;
                if (cnt_q == LAST) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        waddr_o          = (state_q == WRITE) ? cnt_q : holdAddr_q;
        din_o            = (state_q == WRITE) ? pattern(cnt_q[2*DATA_W-1:0], seed_q) : holdDin_q;
        raddr_o          = (state_q == READ) ? cnt_q : raddrHold_q;
        busy_o           = (state_q == WRITE) || (state_q == READ) || (state_q == DRAIN);
        done_o           = (state_q == DONE);
        pass_o           = (state_q == DONE) && (errCount_q == '0);
        err_count_o      = errCount_q;
        first_err_addr_o = firstErr_q;
    end

endmodule
